// File: rtl/sprite_update_scheduler_pkg.sv
// Shared constants and types for the sprite update scheduler slice.
package sprite_update_scheduler_pkg;

    // Default visible-area limits (exclusive upper bounds).
    localparam int SCREEN_WIDTH_DEF  = 640;
    localparam int SCREEN_HEIGHT_DEF = 480;

    // Sprite index assignments.
    localparam int TARGET  = 0;
    localparam int TORPEDO = 1;

    // Sweep controller states.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } sweep_state_e;

endpackage

// File: rtl/sprite_update_scheduler_adder.sv
// Shared position adder: adds a sign-extended velocity to a position and
// reports whether the resulting position lies inside the visible area.
// Purely combinational; wraps modulo 2^X_WIDTH / 2^Y_WIDTH.
module sprite_position_adder #(
    parameter int X_WIDTH       = 10,
    parameter int Y_WIDTH       = 10,
    parameter int D_WIDTH       = 3,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480
) (
    input  logic [X_WIDTH-1:0] x_i,
    input  logic [Y_WIDTH-1:0] y_i,
    input  logic [D_WIDTH-1:0] dx_i,
    input  logic [D_WIDTH-1:0] dy_i,
    output logic [X_WIDTH-1:0] new_x_o,
    output logic [Y_WIDTH-1:0] new_y_o,
    output logic               within_screen_o
);

    // One extra bit so a limit equal to 2^WIDTH still compares correctly.
    localparam logic [X_WIDTH:0] X_LIM = (X_WIDTH+1)'(SCREEN_WIDTH);
    localparam logic [Y_WIDTH:0] Y_LIM = (Y_WIDTH+1)'(SCREEN_HEIGHT);

    assign new_x_o = x_i + {{(X_WIDTH-D_WIDTH){dx_i[D_WIDTH-1]}}, dx_i};
    assign new_y_o = y_i + {{(Y_WIDTH-D_WIDTH){dy_i[D_WIDTH-1]}}, dy_i};
    assign within_screen_o = ({1'b0, new_x_o} < X_LIM) && ({1'b0, new_y_o} < Y_LIM);

endmodule

// File: rtl/sprite_update_scheduler.sv
// Sprite update scheduler: holds per-sprite position/velocity registers and
// sweeps them one per cycle through a single shared adder after each frame tick.
// Writes from the game master always win over the sweep for the same sprite.
module sprite_update_scheduler
    import sprite_update_scheduler_pkg::*;
#(
    parameter int N_SPRITES     = 2,
    parameter int X_WIDTH       = 10,
    parameter int Y_WIDTH       = 10,
    parameter int D_WIDTH       = 3,
    parameter int SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
    parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           frame_tick,
    input  logic [N_SPRITES-1:0]           write_xy,
    input  logic [N_SPRITES-1:0]           write_dxy,
    input  logic [N_SPRITES-1:0]           enable_update,
    input  logic [X_WIDTH-1:0]             load_x,
    input  logic [Y_WIDTH-1:0]             load_y,
    input  logic [D_WIDTH-1:0]             load_dx,
    input  logic [D_WIDTH-1:0]             load_dy,
    output logic [N_SPRITES*X_WIDTH-1:0]   sprite_x,
    output logic [N_SPRITES*Y_WIDTH-1:0]   sprite_y,
    output logic [N_SPRITES-1:0]           within_screen,
    output logic                           busy,
    output logic                           update_done,
    output logic                           overrun
);

    localparam int IDX_W = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SPRITES-1);
    localparam logic [X_WIDTH:0] X_LIM    = (X_WIDTH+1)'(SCREEN_WIDTH);
    localparam logic [Y_WIDTH:0] Y_LIM    = (Y_WIDTH+1)'(SCREEN_HEIGHT);

    sweep_state_e          state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ovr_q, ovr_d;

    logic [X_WIDTH-1:0]    x_q  [N_SPRITES];
    logic [X_WIDTH-1:0]    x_d  [N_SPRITES];
    logic [Y_WIDTH-1:0]    y_q  [N_SPRITES];
    logic [Y_WIDTH-1:0]    y_d  [N_SPRITES];
    logic [D_WIDTH-1:0]    dx_q [N_SPRITES];
    logic [D_WIDTH-1:0]    dx_d [N_SPRITES];
    logic [D_WIDTH-1:0]    dy_q [N_SPRITES];
    logic [D_WIDTH-1:0]    dy_d [N_SPRITES];

    // The on-screen flag of a freshly changed position is staged one cycle so
    // within_screen trails the position registers by exactly one edge.
    logic [N_SPRITES-1:0]  within_q, within_d;
    logic [N_SPRITES-1:0]  pend_q, pend_d;
    logic [N_SPRITES-1:0]  pend_val_q, pend_val_d;

    logic [X_WIDTH-1:0]    add_x_s;
    logic [Y_WIDTH-1:0]    add_y_s;
    logic                  add_within_s;
    logic                  load_within_s;

    sprite_position_adder #(
        .X_WIDTH       (X_WIDTH),
        .Y_WIDTH       (Y_WIDTH),
        .D_WIDTH       (D_WIDTH),
        .SCREEN_WIDTH  (SCREEN_WIDTH),
        .SCREEN_HEIGHT (SCREEN_HEIGHT)
    ) u_adder (
        .x_i             (x_q[idx_q]),
        .y_i             (y_q[idx_q]),
        .dx_i            (dx_q[idx_q]),
        .dy_i            (dy_q[idx_q]),
        .new_x_o         (add_x_s),
        .new_y_o         (add_y_s),
        .within_screen_o (add_within_s)
    );

    assign load_within_s = ({1'b0, load_x} < X_LIM) && ({1'b0, load_y} < Y_LIM);

    // Sweep controller: start on tick from idle, step idx, flag done/overrun.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovr_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_tick) begin
                    state_d = ST_SWEEP;
                    idx_d   = {IDX_W{1'b0}};
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            ST_SWEEP: begin
                ovr_d = frame_tick;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    idx_d   = {IDX_W{1'b0}};
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = {IDX_W{1'b0}};
                busy_d  = 1'b0;
            end
        endcase
    end

    // Per-sprite next state: a write beats the sweep's update of the same sprite.
    always_comb begin
        for (int i = 0; i < N_SPRITES; i++) begin
            x_d[i]        = x_q[i];
            y_d[i]        = y_q[i];
            dx_d[i]       = dx_q[i];
            dy_d[i]       = dy_q[i];
            pend_d[i]     = 1'b0;
            pend_val_d[i] = pend_val_q[i];
            within_d[i]   = pend_q[i] ? pend_val_q[i] : within_q[i];
            if (write_xy[i]) begin
                x_d[i]        = load_x;
                y_d[i]        = load_y;
                pend_d[i]     = 1'b1;
                pend_val_d[i] = load_within_s;
            end else if ((state_q == ST_SWEEP) && (idx_q == IDX_W'(i)) && enable_update[i]) begin
                x_d[i]        = add_x_s;
                y_d[i]        = add_y_s;
                pend_d[i]     = 1'b1;
                pend_val_d[i] = add_within_s;
            end else begin
                pend_d[i]     = 1'b0;
            end
            if (write_dxy[i]) begin
                dx_d[i] = load_dx;
                dy_d[i] = load_dy;
            end else begin
                dx_d[i] = dx_q[i];
                dy_d[i] = dy_q[i];
            end
        end
    end

    // State, sprite and flag registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= {IDX_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            within_q   <= {N_SPRITES{1'b1}};
            pend_q     <= {N_SPRITES{1'b0}};
            pend_val_q <= {N_SPRITES{1'b1}};
            for (int i = 0; i < N_SPRITES; i++) begin
                x_q[i]  <= {X_WIDTH{1'b0}};
                y_q[i]  <= {Y_WIDTH{1'b0}};
                dx_q[i] <= {D_WIDTH{1'b0}};
                dy_q[i] <= {D_WIDTH{1'b0}};
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
            within_q   <= within_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            for (int i = 0; i < N_SPRITES; i++) begin
                x_q[i]  <= x_d[i];
                y_q[i]  <= y_d[i];
                dx_q[i] <= dx_d[i];
                dy_q[i] <= dy_d[i];
            end
        end
    end

    for (genvar g = 0; g < N_SPRITES; g++) begin : g_pack
        assign sprite_x[g*X_WIDTH +: X_WIDTH] = x_q[g];
        assign sprite_y[g*Y_WIDTH +: Y_WIDTH] = y_q[g];
    end

    assign within_screen = within_q;
    assign busy          = busy_q;
    assign update_done   = done_q;
    assign overrun       = ovr_q;

endmodule
